// File: rtl/io_panel_driver.sv
// Switch debouncer and 8-digit multiplexed hex display for a CPU I/O panel.
// Optional build macro LEADING_ZERO_BLANK_EN blanks zero-valued high-nibble digits.
module io_panel_driver #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned SCAN_CYCLES     = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [17:0] sw,
    output logic [5:0]  in_port0,
    output logic [5:0]  in_port1,
    output logic [5:0]  in_port2,
    input  logic [31:0] out_port0,
    input  logic [31:0] out_port1,
    input  logic [31:0] out_port2,
    input  logic [31:0] out_port3,
    output logic [6:0]  seg,
    output logic [7:0]  an
);

    localparam logic [15:0] DebLast  = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] ScanLast = 16'(SCAN_CYCLES - 1);

    // ---------------------------------------------------------------- debounce
    logic [5:0] sw_grp [3];
    logic [5:0] deb    [3];

    assign sw_grp[0] = sw[5:0];
    assign sw_grp[1] = sw[11:6];
    assign sw_grp[2] = sw[17:12];

    for (genvar g = 0; g < 3; g++) begin : g_deb
        logic [5:0]  sync1_q;
        logic [5:0]  sync2_q;
        logic [5:0]  deb_q;
        logic [15:0] cnt_q;

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                sync1_q <= '0;
                sync2_q <= '0;
                deb_q   <= '0;
                cnt_q   <= '0;
            end else begin
                sync1_q <= sw_grp[g];
                sync2_q <= sync1_q;
                if (sync2_q == deb_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == DebLast) begin
                    deb_q <= sync2_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end
        end

        assign deb[g] = deb_q;
    end

    assign in_port0 = deb[0];
    assign in_port1 = deb[1];
    assign in_port2 = deb[2];

    // ----------------------------------------------------------------- display
    logic [15:0] pre_q;
    logic [2:0]  dig_q;
    logic [7:0]  shadow_q [4];
    logic        pre_wrap;
    logic [7:0]  cur_byte;
    logic [3:0]  nib;
    logic [6:0]  seg_d;
    logic [7:0]  an_d;
    logic [6:0]  seg_q;
    logic [7:0]  an_q;
    logic        unused_hi;

    // Only the low byte of each CPU port is displayed.
    assign unused_hi = ^{out_port0[31:8], out_port1[31:8], out_port2[31:8], out_port3[31:8]};

    assign pre_wrap = (pre_q == ScanLast);

    // Shadow bytes reload only at the frame boundary so one frame never mixes values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pre_q <= '0;
            dig_q <= '0;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            pre_q <= pre_wrap ? 16'd0 : pre_q + 16'd1;
            if (pre_wrap) begin
                dig_q <= dig_q + 3'd1;
            end
            if (pre_wrap && (dig_q == 3'd7)) begin
                shadow_q[0] <= out_port0[7:0];
                shadow_q[1] <= out_port1[7:0];
                shadow_q[2] <= out_port2[7:0];
                shadow_q[3] <= out_port3[7:0];
            end
        end
    end

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        cur_byte = shadow_q[dig_q[2:1]];
        nib      = dig_q[0] ? cur_byte[7:4] : cur_byte[3:0];
        seg_d    = hex_seg(nib);
`ifdef LEADING_ZERO_BLANK_EN
        if (dig_q[0] && (nib == 4'h0)) begin
            seg_d = 7'h7F;
        end
`endif
        an_d = (pre_q == 16'd0) ? 8'hFF : ~(8'b1 << dig_q);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            seg_q <= 7'h7F;
            an_q  <= 8'hFF;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_io_panel_driver.sv
// Self-checking bench for io_panel_driver: debounce timing sequences and
// table-driven display frames checked through an expected-value queue.
`timescale 1ns/1ps
module tb_io_panel_driver;

    localparam int unsigned DB = 4;
    localparam int unsigned SC = 2;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011;
    localparam logic [6:0] SC_ = 7'b1000110, SD = 7'b0100001, SE = 7'b0000110;
    localparam logic [6:0] SF = 7'b0001110;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZH = 7'h7F;
`else
    localparam logic [6:0] ZH = S0;
`endif

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [17:0] sw = '0;
    logic [5:0]  in_port0, in_port1, in_port2;
    logic [31:0] out_port0 = '0, out_port1 = '0, out_port2 = '0, out_port3 = '0;
    logic [6:0]  seg;
    logic [7:0]  an;

    always #5 clock = ~clock;

    io_panel_driver #(
        .DEBOUNCE_CYCLES(DB),
        .SCAN_CYCLES    (SC)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .sw       (sw),
        .in_port0 (in_port0),
        .in_port1 (in_port1),
        .in_port2 (in_port2),
        .out_port0(out_port0),
        .out_port1(out_port1),
        .out_port2(out_port2),
        .out_port3(out_port3),
        .seg      (seg),
        .an       (an)
    );

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
    } exp_t;

    typedef struct packed {
        logic [3:0][7:0] b;  // port bytes, b[0] = out_port0
        logic [7:0][6:0] s;  // expected seg per digit, s[0] = digit 0
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs [4];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    task automatic wait_an(input logic [7:0] target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            if (an === target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drive_ports(input vec_t v);
        out_port0 = {24'hA5C3F1, v.b[0]};
        out_port1 = {24'h5A3C1F, v.b[1]};
        out_port2 = {24'hFFFFFF, v.b[2]};
        out_port3 = {24'h123456, v.b[3]};
    endtask

    task automatic push_vec(input vec_t v, input int first, input int n);
        exp_t e;
        for (int i = first; i < first + n; i++) begin
            e.an  = ~(8'b1 << i);
            e.seg = v.s[i];
            sb_q.push_back(e);
        end
    endtask

    // Compare n consecutive lit digits, starting with digit 'first', against the queue.
    task automatic check_seq(input int first, input int n);
        bit         ok;
        exp_t       e;
        logic [7:0] tgt;
        tgt = ~(8'b1 << first);
        wait_an(tgt, ok);
        if (!ok) begin
            timeout_fail("digit_sync");
            for (int i = 0; i < n; i++) void'(sb_q.pop_front());
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                ok = 1'b0;
                for (int k = 0; k < 16; k++) begin
                    @(negedge clock);
                    if (an !== 8'hFF) begin
                        ok = 1'b1;
                        break;
                    end
                end
                if (!ok) begin
                    timeout_fail("digit_advance");
                    for (int j = i; j < n; j++) void'(sb_q.pop_front());
                    return;
                end
            end
            e = sb_q.pop_front();
            chk("scan_an", 32'(an), 32'(e.an));
            chk("scan_seg", 32'(seg), 32'(e.seg));
        end
    endtask

    // Skip one frame so the checked frame was loaded after the ports changed.
    task automatic check_frame();
        bit ok;
        wait_an(8'hFE, ok);
        if (!ok) timeout_fail("frame_skip");
        wait_an(8'hFF, ok);
        if (!ok) timeout_fail("frame_blank");
        check_seq(0, 8);
    endtask

    initial begin : main
        bit ok;

        vecs[0].b = {8'h76, 8'h54, 8'h32, 8'h10};
        vecs[0].s = {S7, S6, S5, S4, S3, S2, S1, S0};
        vecs[1].b = {8'hFE, 8'hDC, 8'hBA, 8'h98};
        vecs[1].s = {SF, SE, SD, SC_, SB, SA, S9, S8};
        vecs[2].b = {8'h00, 8'hC5, 8'h07, 8'h11};
        vecs[2].s = {ZH, S0, SC_, S5, ZH, S7, S1, S1};
        vecs[3].b = {8'h9E, 8'h6D, 8'h3B, 8'h22};
        vecs[3].s = {S9, SE, S6, SD, S3, SB, S2, S2};

        // Reset state with busy inputs.
        sw        = 18'h3FFFF;
        out_port0 = '1;
        repeat (3) @(negedge clock);
        chk("rst_in_port0", 32'(in_port0), 32'h0);
        chk("rst_in_port1", 32'(in_port1), 32'h0);
        chk("rst_in_port2", 32'(in_port2), 32'h0);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_an", 32'(an), 32'hFF);
        sw        = '0;
        out_port0 = '0;
        resetn    = 1'b1;
        repeat (4) @(negedge clock);

        // Held change appears after edge 2+DB and not before.
        sw[5:0] = 6'h2A;
        for (int e = 1; e <= 6; e++) begin
            @(negedge clock);
            chk($sformatf("deb0_edge%0d", e), 32'(in_port0), (e >= 6) ? 32'h2A : 32'h0);
        end
        chk("deb0_in_port1", 32'(in_port1), 32'h0);
        chk("deb0_in_port2", 32'(in_port2), 32'h0);

        // Two 3-cycle glitches separated by one quiet cycle never pass.
        for (int c = 0; c < 16; c++) begin
            sw[11:6] = ((c < 3) || (c >= 4 && c < 7)) ? 6'h3F : 6'h00;
            @(negedge clock);
            chk($sformatf("glitch1_c%0d", c), 32'(in_port1), 32'h0);
        end

        // Simultaneous changes in all three groups settle independently.
        sw = {6'h0A, 6'h15, 6'h00};
        for (int e = 1; e <= 6; e++) begin
            @(negedge clock);
            chk($sformatf("multi0_edge%0d", e), 32'(in_port0), (e >= 6) ? 32'h0 : 32'h2A);
            chk($sformatf("multi1_edge%0d", e), 32'(in_port1), (e >= 6) ? 32'h15 : 32'h0);
            chk($sformatf("multi2_edge%0d", e), 32'(in_port2), (e >= 6) ? 32'h0A : 32'h0);
        end
        sw[5:0] = 6'h2A;
        repeat (8) @(negedge clock);
        chk("reload_in_port0", 32'(in_port0), 32'h2A);

        // Table-driven frames covering all sixteen glyphs and zero high nibbles.
        for (int v = 0; v < 3; v++) begin
            drive_ports(vecs[v]);
            push_vec(vecs[v], 0, 8);
            check_frame();
        end

        // Ports change at digit 3: rest of this frame keeps old values, next frame is new.
        wait_an(8'hF7, ok);
        if (!ok) timeout_fail("midframe_sync");
        drive_ports(vecs[3]);
        push_vec(vecs[2], 4, 4);
        push_vec(vecs[3], 0, 8);
        check_seq(4, 4);
        check_seq(0, 8);

        // Reset during digit 5 darkens immediately and restarts scanning at digit 0.
        wait_an(8'hDF, ok);
        if (!ok) timeout_fail("rst_mid_sync");
        resetn = 1'b0;
        #1;
        chk("rstmid_in_port0", 32'(in_port0), 32'h0);
        chk("rstmid_an", 32'(an), 32'hFF);
        chk("rstmid_seg", 32'(seg), 32'h7F);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        chk("restart_blank_an", 32'(an), 32'hFF);
        @(negedge clock);
        chk("restart_d0_an", 32'(an), 32'hFE);
        chk("restart_d0_seg", 32'(seg), 32'(S0));
        chk("restart_in_port0", 32'(in_port0), 32'h0);
        repeat (6) @(negedge clock);
        chk("restart_deb0", 32'(in_port0), 32'h2A);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
